mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the IF-stage instruction requester and the EX/ME-stage data requester.
//  Allows exactly one outstanding transaction at a time. Data requests have priority, with an anti-starvation limit for fetch.
//  Sits between the pipeline stages and the single external memory/bus bridge port.
// PARAMETERS
//  ADDR_W        32  address width of all ports
//  DATA_W        32  data width of all ports; wstrb is DATA_W/8 bits
//  STARVE_LIMIT  4   consecutive data grants while inst waits before inst is forced; 0 = inst always wins a tie
// PORTS
//  clk           in   1        single clock, rising edge
//  resetn        in   1        asynchronous, active-low reset
//  inst_req      in   1        fetch request; held with inst_addr until inst_addr_ok
//  inst_addr     in   ADDR_W   fetch address
//  inst_addr_ok  out  1        1-cycle pulse: fetch request accepted
//  inst_data_ok  out  1        1-cycle pulse: fetch data valid on inst_rdata
//  inst_rdata    out  DATA_W   fetch read data, registered
//  data_req      in   1        load/store request; held with fields until data_addr_ok
//  data_wr       in   1        1 = store, 0 = load
//  data_wstrb    in   DATA_W/8 store byte enables
//  data_addr     in   ADDR_W   load/store address
//  data_wdata    in   DATA_W   store data
//  data_addr_ok  out  1        1-cycle pulse: data request accepted
//  data_data_ok  out  1        1-cycle pulse: load data valid, or store done
//  data_rdata    out  DATA_W   load read data, registered
//  mem_req       out  1        shared port request
//  mem_wr        out  1        shared port write flag
//  mem_wstrb     out  DATA_W/8 shared port byte enables; forced 0 for reads
//  mem_addr      out  ADDR_W   shared port address
//  mem_wdata     out  DATA_W   shared port write data
//  mem_addr_ok   in   1        slave accepted address in the current cycle
//  mem_data_ok   in   1        slave returns data or write acknowledge
//  mem_rdata     in   DATA_W   slave read data
// BEHAVIOUR
//  Reset (resetn=0, async):
//   - state=IDLE; streak=0; owner=INST.
//   - All outputs 0, including the rdata registers. Any in-flight transaction is dropped; the slave is reset together with this block.
//  FSM: IDLE -> ADDR -> DATA -> IDLE.
//  IDLE, cycle T, arbitration when any req is high:
//   - Grant inst if inst_req && (!data_req || streak==STARVE_LIMIT); otherwise grant data.
//   - At edge T: latch owner, addr, wr, wstrb, wdata; go to ADDR.
//   - Inst latches wr=0 and wstrb=0. Data latches wstrb=0 when data_wr=0.
//  Acceptance, cycle T+1:
//   - Owner's *_addr_ok pulses high for one cycle, registered.
//   - The requester may drop or change req from T+1; the latched transaction always completes.
//  ADDR state:
//   - mem_req=1 and the mem_* fields are driven from the latch, stable until mem_addr_ok.
//   - On mem_addr_ok go to DATA; mem_req=0 from the next cycle.
//  DATA state:
//   - mem_req=0; wait for mem_data_ok, cycle D.
//   - At edge D, for a read, load mem_rdata into the owner's rdata register. A write leaves both rdata registers unchanged.
//   - Owner's *_data_ok pulses in D+1; state is IDLE in D+1, which can arbitrate a new request in D+1.
//  mem_data_ok outside DATA is ignored. The slave contract is data_ok at least 1 cycle after addr_ok.
//  Streak counter, updated at the grant edge:
//   - Data grant with inst_req high: streak+1, saturating at STARVE_LIMIT.
//   - Data grant with inst_req low: streak=0.
//   - Inst grant: streak=0.
//  Minimum latency: request to addr_ok is 1 cycle; request to data_ok is 3 cycles (mem_addr_ok at T+1, mem_data_ok at T+2).
//  Never more than one mem transaction is outstanding. Only one addr_ok and one data_ok pulse occur per transaction.
// TESTING
//  1. Inst read: inst_addr=0x1c000000; mem_addr_ok at T+1; mem_data_ok at T+3 with rdata=0x02800c0c
//     -> inst_addr_ok at T+1; mem_req at T+1..T+1 with addr 0x1c000000, wr=0;
//     -> inst_data_ok at T+4; inst_rdata=0x02800c0c.
//  2. inst_req and data_req both raised at T -> data_addr_ok at T+1; inst is served next, inst_addr_ok one cycle after data_data_ok.
//  3. STARVE_LIMIT=2, inst_req and data_req held high continuously -> grant order D,D,I,D,D,I.
//  4. Store: addr 0x1c008000, wdata 0xdeadbeef, wstrb 4'b0011
//     -> mem_wr=1, mem_wstrb=0011, mem_wdata=0xdeadbeef; data_data_ok pulses; data_rdata unchanged.
//  5. mem_addr_ok held low for 5 cycles -> mem_req and all mem_* fields stable; no extra addr_ok; new reqs stay pending.
//  6. resetn=0 during DATA -> all outputs 0 immediately.
//     After release, a fetch from 0x1c000000 completes normally; no stale data_ok appears.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch and load/store requesters.
// One transaction in flight at a time; data wins ties unless fetch has been starved.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          state_o
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                owner_data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                inst_addr_ok_q, data_addr_ok_q;
    logic                inst_data_ok_q, data_data_ok_q;
    logic [DATA_W-1:0]   inst_rdata_q, data_rdata_q;

    logic grant, grant_inst, done;

    // Fetch wins only when data is absent or data has hit the streak cap.
    assign grant_inst = inst_req && (!data_req || (streak_q == STREAK_MAX));
    assign grant      = (state_q == IDLE) && (inst_req || data_req);
    assign done       = (state_q == DATA) && mem_data_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inst_req || data_req) state_d = ADDR;
            ADDR:    if (mem_addr_ok)          state_d = DATA;
            DATA:    if (mem_data_ok)          state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req      = (state_q == ADDR);
        mem_wr       = wr_q;
        mem_wstrb    = wstrb_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        inst_addr_ok = inst_addr_ok_q;
        data_addr_ok = data_addr_ok_q;
        inst_data_ok = inst_data_ok_q;
        data_data_ok = data_data_ok_q;
        inst_rdata   = inst_rdata_q;
        data_rdata   = data_rdata_q;
        state_o      = state_q;
    end

    always_comb begin
        streak_d = streak_q;
        if (grant) begin
            if (grant_inst || !inst_req) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak_q       <= '0;
            owner_data_q   <= 1'b0;
            addr_q         <= '0;
            wr_q           <= 1'b0;
            wstrb_q        <= '0;
            wdata_q        <= '0;
            inst_addr_ok_q <= 1'b0;
            data_addr_ok_q <= 1'b0;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= '0;
            data_rdata_q   <= '0;
        end else begin
            streak_q       <= streak_d;
            inst_addr_ok_q <= grant && grant_inst;
            data_addr_ok_q <= grant && !grant_inst;
            inst_data_ok_q <= done && !owner_data_q;
            data_data_ok_q <= done && owner_data_q;
            if (grant) begin
                owner_data_q <= !grant_inst;
                addr_q       <= grant_inst ? inst_addr : data_addr;
                wr_q         <= !grant_inst && data_wr;
                wstrb_q      <= (!grant_inst && data_wr) ? data_wstrb : '0;
                wdata_q      <= grant_inst ? '0 : data_wdata;
            end
            // Writes complete without touching either read-data register.
            if (done && !wr_q) begin
                if (owner_data_q) begin
                    data_rdata_q <= mem_rdata;
                end else begin
                    inst_rdata_q <= mem_rdata;
                end
            end
        end
    end
endmodule
